// File: rtl/fp_soc_nios2_gen2_0_cpu_ocimem_pkg.sv
// Shared types and constants for the OCIMEM arbiter slice.
package fp_soc_nios2_gen2_0_cpu_ocimem_pkg;

  localparam int OCIMEM_ADDR_W = 8;
  localparam int OCIMEM_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {GNT_JTAG, GNT_AV} gnt_e;

endpackage

// File: rtl/fp_soc_nios2_gen2_0_cpu_ocimem_jtag_hold.sv
// One-entry holding register for JTAG debug commands plus sticky overrun flag.
// The JTAG side has no backpressure, so a pulse arriving while a command is
// still outstanding is dropped and flagged. The command view (cmd_*) also
// forwards a live pulse so an idle arbiter can grant it in the same cycle.
module fp_soc_nios2_gen2_0_cpu_ocimem_jtag_hold
  import fp_soc_nios2_gen2_0_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = OCIMEM_ADDR_W,
  parameter int DATA_W = OCIMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  input  logic              ovr_clr,
  output logic              cmd_vld,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic              overrun
);

  logic              pend;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cap;
  logic              drop;

  // completion frees the slot before a same-cycle pulse is considered
  assign cap  = req && (!pend || clr);
  assign drop = req && pend && !clr;

  // holding register and overrun flag; a new overrun beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      overrun <= 1'b0;
    end else begin
      if (cap) begin
        pend    <= 1'b1;
        wr_q    <= wr;
        addr_q  <= addr;
        wdata_q <= wdata;
      end else if (clr) begin
        pend <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign cmd_vld   = pend | req;
  assign cmd_wr    = pend ? wr_q    : wr;
  assign cmd_addr  = pend ? addr_q  : addr;
  assign cmd_wdata = pend ? wdata_q : wdata;

endmodule

// File: rtl/fp_soc_nios2_gen2_0_cpu_ocimem_arbiter.sv
// OCIMEM port arbiter: JTAG debug command path vs. CPU Avalon debug_mem_slave.
// Sequence per access: IDLE -> ISSUE -> (reads: WAIT x RAM_LAT-1) -> DONE.
// Read data arrives from the RAM in the DONE cycle. Avalon sees it through a
// bypass in that cycle; both requesters' read data is also registered at the
// end of DONE (jtag_rdata holds from then until the next JTAG read).
// Build option FP_SOC_OCIMEM_ARB_JTAG_PRI_EN: fixed priority, JTAG always wins;
// otherwise round-robin between the two requesters.
module fp_soc_nios2_gen2_0_cpu_ocimem_arbiter
  import fp_soc_nios2_gen2_0_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W  = OCIMEM_ADDR_W,
  parameter int DATA_W  = OCIMEM_DATA_W,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  output logic              jtag_done,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_overrun,
  input  logic              ovr_clr,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic              av_waitreq,
  output logic [DATA_W-1:0] av_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // WAIT counts down from here to 0, giving RAM_LAT-1 wait cycles
  localparam logic [1:0] WAIT_INIT = (RAM_LAT > 1) ? 2'(RAM_LAT - 2) : 2'd0;

  state_e            state;
  gnt_e              gnt;
  gnt_e              pick;
  logic              op_wr;
  logic [1:0]        wait_cnt;
  logic [DATA_W-1:0] av_rdata_q;
  logic              j_vld;
  logic              j_wr;
  logic [ADDR_W-1:0] j_addr;
  logic [DATA_W-1:0] j_wdata;
  logic              av_vld;
`ifndef FP_SOC_OCIMEM_ARB_JTAG_PRI_EN
  gnt_e              rr_last;
`endif

  fp_soc_nios2_gen2_0_cpu_ocimem_jtag_hold #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (jtag_req),
    .wr        (jtag_wr),
    .addr      (jtag_addr),
    .wdata     (jtag_wdata),
    .clr       (jtag_done),
    .ovr_clr   (ovr_clr),
    .cmd_vld   (j_vld),
    .cmd_wr    (j_wr),
    .cmd_addr  (j_addr),
    .cmd_wdata (j_wdata),
    .overrun   (jtag_overrun)
  );

  // read+write together is treated as a write
  assign av_vld = av_read | av_write;

  // winner selection among pending requesters
  always_comb begin
    pick = GNT_AV;
`ifdef FP_SOC_OCIMEM_ARB_JTAG_PRI_EN
    if (j_vld) pick = GNT_JTAG;
`else
    if (j_vld && av_vld) pick = (rr_last == GNT_AV) ? GNT_JTAG : GNT_AV;
    else if (j_vld)      pick = GNT_JTAG;
`endif
  end

  // access sequencer with registered RAM strobes and completion outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= GNT_AV;
`ifndef FP_SOC_OCIMEM_ARB_JTAG_PRI_EN
      rr_last    <= GNT_AV;
`endif
      op_wr      <= 1'b0;
      wait_cnt   <= 2'd0;
      ram_addr   <= '0;
      ram_wr     <= 1'b0;
      ram_rd     <= 1'b0;
      ram_wdata  <= '0;
      jtag_done  <= 1'b0;
      av_waitreq <= 1'b1;
      jtag_rdata <= '0;
      av_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (j_vld || av_vld) begin
            state <= ISSUE;
            gnt   <= pick;
`ifndef FP_SOC_OCIMEM_ARB_JTAG_PRI_EN
            rr_last <= pick;
`endif
            if (pick == GNT_JTAG) begin
              op_wr     <= j_wr;
              ram_addr  <= j_addr;
              ram_wdata <= j_wdata;
              ram_wr    <= j_wr;
              ram_rd    <= !j_wr;
            end else begin
              op_wr     <= av_write;
              ram_addr  <= av_address;
              ram_wdata <= av_writedata;
              ram_wr    <= av_write;
              ram_rd    <= !av_write;
            end
          end
        end
        ISSUE: begin
          ram_wr <= 1'b0;
          ram_rd <= 1'b0;
          if (op_wr || RAM_LAT <= 1) begin
            state      <= DONE;
            jtag_done  <= (gnt == GNT_JTAG);
            av_waitreq <= (gnt == GNT_JTAG);
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            state      <= DONE;
            jtag_done  <= (gnt == GNT_JTAG);
            av_waitreq <= (gnt == GNT_JTAG);
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          jtag_done  <= 1'b0;
          av_waitreq <= 1'b1;
          if (!op_wr && gnt == GNT_JTAG) jtag_rdata <= ram_rdata;
          if (!op_wr && gnt == GNT_AV)   av_rdata_q <= ram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Avalon sees RAM data directly in its DONE cycle, the registered copy otherwise
  assign av_readdata = (state == DONE && gnt == GNT_AV && !op_wr) ? ram_rdata : av_rdata_q;

endmodule

// File: tb/tb_fp_soc_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Scoreboard bench: stimulus pushes expected completions, a negedge monitor
// pops and compares. Instance u_dut uses RAM_LAT=1, u_dut3 uses RAM_LAT=3
// for the mid-read reset scenario. JTAG uses addresses 0x00-0x7F and Avalon
// 0x80-0xFF during contention so each requester's data model is independent.
module tb_fp_soc_nios2_gen2_0_cpu_ocimem_arbiter;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          t0;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, rst_b;
  logic        jtag_req, b_jtag_req, jtag_wr, ovr_clr;
  logic [7:0]  jtag_addr;
  logic [31:0] jtag_wdata;
  logic        av_read, av_write;
  logic [7:0]  av_address;
  logic [31:0] av_writedata;

  logic        jtag_done, jtag_overrun, av_waitreq, ram_wr, ram_rd;
  logic [31:0] jtag_rdata, av_readdata, ram_wdata, ram_rdata;
  logic [7:0]  ram_addr;

  logic        b_jtag_done, b_jtag_overrun, b_av_waitreq, b_ram_wr, b_ram_rd;
  logic [31:0] b_jtag_rdata, b_av_readdata, b_ram_wdata, b_ram_rdata;
  logic [7:0]  b_ram_addr;

  fp_soc_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32), .RAM_LAT(1)) u_dut (
    .clk(clk), .reset_n(rst_a),
    .jtag_req(jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_done(jtag_done), .jtag_rdata(jtag_rdata), .jtag_overrun(jtag_overrun), .ovr_clr(ovr_clr),
    .av_address(av_address), .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
    .av_waitreq(av_waitreq), .av_readdata(av_readdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  fp_soc_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32), .RAM_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(rst_b),
    .jtag_req(b_jtag_req), .jtag_wr(jtag_wr), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_done(b_jtag_done), .jtag_rdata(b_jtag_rdata), .jtag_overrun(b_jtag_overrun), .ovr_clr(1'b0),
    .av_address(8'h00), .av_read(1'b0), .av_write(1'b0), .av_writedata(32'h0),
    .av_waitreq(b_av_waitreq), .av_readdata(b_av_readdata),
    .ram_addr(b_ram_addr), .ram_wr(b_ram_wr), .ram_rd(b_ram_rd), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // environment RAMs (not the reference model)
  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];
  logic [31:0] b_p1, b_p2;
  always @(posedge clk) begin
    if (ram_wr) ram_a[ram_addr] <= ram_wdata;
    ram_rdata <= ram_a[ram_addr];
    if (b_ram_wr) ram_b[b_ram_addr] <= b_ram_wdata;
    b_p1 <= ram_b[b_ram_addr];
    b_p2 <= b_p1;
    b_ram_rdata <= b_p2;
  end

  // reference model: memory contents as seen by the requesters
  logic [31:0] mdl [256];
  exp_t jq[$];
  exp_t aq[$];
  bit   glog[$];   // grant order: 0 = JTAG, 1 = Avalon (by address range)
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT signals completion
  bit          rd_pend = 0;
  logic [31:0] rd_exp;
  exp_t        me;
  always @(negedge clk) begin
    if (rd_pend) begin
      chk("jtag_rdata", jtag_rdata, rd_exp);
      rd_pend = 0;
    end
    if (rst_a) begin
      if (ram_wr || ram_rd) glog.push_back(ram_addr[7]);
      if (jtag_done) begin
        if (jq.size() == 0) begin
          checks++; failures++;
          $display("FAIL jtag_done_unexpected actual=1 expected=0");
        end else begin
          me = jq.pop_front();
          if (me.lat > 0) chk("jtag_latency", cyc - me.t0, me.lat);
          if (me.rd) begin rd_pend = 1; rd_exp = me.data; end
        end
      end
      if (!av_waitreq) begin
        if (aq.size() == 0) begin
          checks++; failures++;
          $display("FAIL av_done_unexpected actual=1 expected=0");
        end else begin
          me = aq.pop_front();
          if (me.lat > 0) chk("av_latency", cyc - me.t0, me.lat);
          if (me.rd) chk("av_readdata", av_readdata, me.data);
        end
      end
    end
  end

  task automatic jtag_issue(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input int lat, input bit expect_done);
    exp_t e;
    if (expect_done) begin
      if (wr) mdl[a] = d;
      e.rd = !wr; e.data = wr ? 32'h0 : mdl[a]; e.t0 = cyc; e.lat = lat;
      jq.push_back(e);
    end
    jtag_wr = wr; jtag_addr = a; jtag_wdata = d; jtag_req = 1'b1;
    @(negedge clk);
    jtag_req = 1'b0;
  endtask

  task automatic jtag_wait_done();
    bit got = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (jtag_done) begin got = 1; break; end
    end
    if (!got) chk("jtag_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic av_access(input bit wr, input logic [7:0] a, input logic [31:0] d, input int lat);
    exp_t e;
    bit got = 0;
    if (wr) mdl[a] = d;
    e.rd = !wr; e.data = wr ? 32'h0 : mdl[a]; e.t0 = cyc; e.lat = lat;
    aq.push_back(e);
    av_read = !wr; av_write = wr; av_address = a; av_writedata = d;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!av_waitreq) begin got = 1; break; end
    end
    if (!got) chk("av_waitreq_timeout", 32'd0, 32'd1);
    av_read = 1'b0; av_write = 1'b0;
  endtask

  logic [31:0] x1, x2;
  int          bdone;

  initial begin
    jtag_req = 0; b_jtag_req = 0; jtag_wr = 0; jtag_addr = 0; jtag_wdata = 0; ovr_clr = 0;
    av_read = 0; av_write = 0; av_address = 0; av_writedata = 0;
    rst_a = 0; rst_b = 0;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = $urandom; mdl[i] = ram_a[i]; ram_b[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    chk("rst_jtag_done", jtag_done, 0);
    chk("rst_av_waitreq", av_waitreq, 1);
    chk("rst_jtag_rdata", jtag_rdata, 0);
    chk("rst_av_readdata", av_readdata, 0);
    chk("rst_ram_strobes", {ram_wr, ram_rd}, 0);
    chk("rst_overrun", jtag_overrun, 0);
    chk("rst_ram_addr", ram_addr, 0);
    rst_a = 1; rst_b = 1;
    @(negedge clk);

    // 1: uncontended JTAG write
    jtag_issue(1, 8'h10, 32'hDEADBEEF, 2, 1);
    chk("t1_ram_wr", ram_wr, 1);
    chk("t1_ram_addr", ram_addr, 8'h10);
    chk("t1_ram_wdata", ram_wdata, 32'hDEADBEEF);
    jtag_wait_done();
    @(negedge clk);

    // 2: uncontended Avalon read of the same word
    av_access(0, 8'h10, 32'h0, 2);
    @(negedge clk);

    // 3: simultaneous requests after an Avalon grant -> JTAG first
    for (int r = 0; r < 3; r++) begin
      glog.delete();
      fork
        begin jtag_issue(1, 8'h30 + 8'(r), $urandom, 0, 1); jtag_wait_done(); end
        av_access(0, 8'h90 + 8'(r), 32'h0, 0);
      join
      @(negedge clk);
      chk("t3_grants", glog.size(), 2);
      chk("t3_first", glog.size() > 0 ? glog[0] : 1'bx, 0);
      chk("t3_second", glog.size() > 1 ? glog[1] : 1'bx, 1);
    end

    // 3b: simultaneous requests after a JTAG grant
    jtag_issue(1, 8'h31, $urandom, 2, 1);
    jtag_wait_done();
    @(negedge clk);
    glog.delete();
    fork
      begin jtag_issue(0, 8'h31, 32'h0, 0, 1); jtag_wait_done(); end
      av_access(1, 8'h95, $urandom, 0);
    join
    @(negedge clk);
    chk("t3b_grants", glog.size(), 2);
`ifdef FP_SOC_OCIMEM_ARB_JTAG_PRI_EN
    chk("t3b_first", glog.size() > 0 ? glog[0] : 1'bx, 0);
`else
    chk("t3b_first", glog.size() > 0 ? glog[0] : 1'bx, 1);
`endif

    // 4: second JTAG pulse while the first is still held -> dropped, overrun
    x1 = $urandom; x2 = ~x1;
    fork
      av_access(0, 8'h91, 32'h0, 0);
      begin
        @(negedge clk);
        jtag_issue(1, 8'h20, x1, 0, 1);
        jtag_issue(1, 8'h21, x2, 0, 0);
      end
    join
    jtag_wait_done();
    @(negedge clk);
    chk("t4_overrun_set", jtag_overrun, 1);
    ovr_clr = 1;
    @(negedge clk);
    ovr_clr = 0;
    chk("t4_overrun_clr", jtag_overrun, 0);
    jtag_issue(0, 8'h21, 32'h0, 2, 1);
    jtag_wait_done();
    @(negedge clk);
    jtag_issue(0, 8'h20, 32'h0, 2, 1);
    jtag_wait_done();
    @(negedge clk);

    // 6: JTAG pending throughout back-to-back Avalon writes
    glog.delete();
    fork
      for (int k = 0; k < 5; k++) begin
        jtag_issue(1, 8'h40 + 8'(k), $urandom, 0, 1);
        jtag_wait_done();
      end
      for (int k = 0; k < 5; k++) av_access(1, 8'hA0 + 8'(k), $urandom, 0);
    join
    @(negedge clk);
    chk("t6_grants", glog.size(), 10);
    for (int i = 1; i < 10; i++) begin
`ifdef FP_SOC_OCIMEM_ARB_JTAG_PRI_EN
      chk($sformatf("t6_grant%0d", i), glog.size() > i ? glog[i] : 1'bx, (i < 5) ? 0 : 1);
`else
      chk($sformatf("t6_alternate%0d", i), glog.size() > i ? (glog[i] != glog[i-1]) : 1'bx, 1);
`endif
    end

    // randomized mixed traffic
    for (int it = 0; it < 30; it++) begin
      fork
        begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          jtag_issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), $urandom, 0, 1);
          jtag_wait_done();
        end
        begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          av_access(1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), $urandom, 0);
        end
      join
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("end_overrun", jtag_overrun, 0);
    chk("end_jq_empty", jq.size(), 0);
    chk("end_aq_empty", aq.size(), 0);

    // 5: reset during WAIT on the RAM_LAT=3 instance
    jtag_wr = 0; jtag_addr = 8'h05; b_jtag_req = 1;
    @(negedge clk);
    b_jtag_req = 0;
    @(negedge clk);
    rst_b = 0;
    @(negedge clk);
    chk("t5_rst_done", b_jtag_done, 0);
    chk("t5_rst_waitreq", b_av_waitreq, 1);
    @(negedge clk);
    chk("t5_rst_done2", b_jtag_done, 0);
    rst_b = 1;
    bdone = 0;
    repeat (8) begin
      @(negedge clk);
      if (b_jtag_done) bdone++;
    end
    chk("t5_no_done_after_reset", bdone, 0);
    chk("t5_waitreq_idle", b_av_waitreq, 1);
    jtag_wr = 1; jtag_addr = 8'h06; jtag_wdata = 32'h12345678; b_jtag_req = 1;
    @(negedge clk);
    b_jtag_req = 0;
    chk("t5_issue_wr", {b_ram_wr, b_ram_addr}, {1'b1, 8'h06});
    chk("t5_done_early", b_jtag_done, 0);
    @(negedge clk);
    chk("t5_done_latency", b_jtag_done, 1);
    chk("t5_overrun", b_jtag_overrun, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
